// File: rtl/triangle_loader_pkg.sv
// Shared rasterizer packet types: Triangle3D (three signed 16-bit vertices) and Color.
package triangle_loader_pkg;
  localparam int COORD_BITS = 16;
  localparam int COLOR_BITS = 24;

  typedef struct packed {
    logic signed [COORD_BITS-1:0] x;
    logic signed [COORD_BITS-1:0] y;
    logic signed [COORD_BITS-1:0] z;
  } Vertex3D;

  typedef struct packed {
    Vertex3D v0;
    Vertex3D v1;
    Vertex3D v2;
  } Triangle3D;

  typedef logic [COLOR_BITS-1:0] Color;
endpackage

// File: rtl/triangle_loader.sv
// Packs 32-bit host words into Triangle3D + Color packets and buffers them in a DEPTH-entry FIFO.
// Optional macro LOADER_DEGEN_CULL_EN drops degenerate triangles and counts them on cull_count.
module triangle_loader
  import triangle_loader_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WORDS = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  data_in,
  input  logic                         data_ready,
  output logic                         data_read,
  output Triangle3D                    triangle,
  output Color                         color,
  output logic                         tri_ready,
  input  logic                         tri_read,
  output logic [$clog2(DEPTH+1)-1:0]   tri_count,
  output logic                         busy
`ifdef LOADER_DEGEN_CULL_EN
  ,
  output logic [15:0]                  cull_count
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  if (WORDS != 10) begin : g_words_chk
    $error("triangle_loader: WORDS is fixed at 10");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("triangle_loader: DEPTH must be a power of two >= 2");
  end

  typedef enum logic {COLLECT, LAST} state_t;

  typedef struct packed {
    Triangle3D tri_f;
    Color      col_f;
  } packet_t;

  state_t                       state_q, state_d;
  logic [3:0]                   word_idx_q, word_idx_d;
  logic signed [COORD_BITS-1:0] asm_q [9];
  packet_t                      mem_q [DEPTH];
  logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         full, xfer, last_xfer, push, pop, degen;
  Triangle3D                    asm_tri;
  logic                         unused_data_hi;

  assign unused_data_hi = ^data_in[31:COLOR_BITS];

  function automatic logic is_degenerate(input Triangle3D t);
    return (t.v0 == t.v1) || (t.v1 == t.v2) || (t.v0 == t.v2);
  endfunction

  assign asm_tri = {asm_q[0], asm_q[1], asm_q[2],
                    asm_q[3], asm_q[4], asm_q[5],
                    asm_q[6], asm_q[7], asm_q[8]};

`ifdef LOADER_DEGEN_CULL_EN
  assign degen = is_degenerate(asm_tri);
`else
  assign degen = 1'b0;
`endif

  // No pop bypass: the word-9 accept decision looks only at the registered count.
  assign full = (count_q == CNT_W'(DEPTH));

  always_comb begin
    data_read = 1'b0;
    if (!rst) begin
      case (state_q)
        COLLECT: data_read = 1'b1;
        LAST:    data_read = !full || degen;
        default: data_read = 1'b0;
      endcase
    end
  end

  assign xfer      = data_ready && data_read;
  assign last_xfer = xfer && (state_q == LAST);
  assign push      = last_xfer && !degen;
  assign pop       = tri_read && tri_ready;

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    case (state_q)
      COLLECT: begin
        if (xfer) begin
          word_idx_d = word_idx_q + 4'd1;
          if (word_idx_q == 4'd8) state_d = LAST;
        end
      end
      LAST: begin
        if (xfer) begin
          word_idx_d = 4'd0;
          state_d    = COLLECT;
        end
      end
      default: begin
        word_idx_d = 4'd0;
        state_d    = COLLECT;
      end
    endcase
  end

  always_comb begin
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      word_idx_q <= 4'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Datapath storage carries no reset; the head outputs are gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (xfer && state_q == COLLECT) asm_q[word_idx_q] <= $signed(data_in[COORD_BITS-1:0]);
    if (push) mem_q[wr_ptr_q] <= '{tri_f: asm_tri, col_f: data_in[COLOR_BITS-1:0]};
  end

`ifdef LOADER_DEGEN_CULL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cull_count <= 16'd0;
    else if (last_xfer && degen) cull_count <= cull_count + 16'd1;
  end
`endif

  assign tri_ready = (count_q != '0);
  assign tri_count = count_q;
  assign triangle  = tri_ready ? mem_q[rd_ptr_q].tri_f : '0;
  assign color     = tri_ready ? mem_q[rd_ptr_q].col_f : '0;
  assign busy      = (word_idx_q != 4'd0) || (count_q != '0);

endmodule
